axis_packet_arbiter: RTL and testbench
======================================

# axis_packet_arbiter

Packet-level round-robin arbiter that shares a single AXI-Stream output channel among `N_PORTS` AXI-Stream requesters. A grant is held for a whole packet, from the first accepted beat through the beat carrying `last`, so packets from different sources never interleave. The block sits between several stream producers (slave side) and one downstream consumer such as a DMA or a serializer (master side), using the same `data`/`valid`/`ready`/`last`/`user` signal set as the rest of the stream fabric.

## Interface
Parameters:
- `N_PORTS`, 4: number of slave (requester) ports; legal range 2..16.
- `bw_data`, 32: data width per port.
- `bw_user`, 8: user sideband width per port.

Ports:
- `Clk` in, 1: single clock; all logic is rising-edge.
- `Rst` in, 1: reset, synchronous, active-high.
- `s_valid` in, `N_PORTS`: per-port valid; bit i belongs to port i.
- `s_ready` out, `N_PORTS`: per-port ready.
- `s_data` in, `N_PORTS*bw_data`: port i occupies `[i*bw_data +: bw_data]`.
- `s_last` in, `N_PORTS`: per-port end of packet.
- `s_user` in, `N_PORTS*bw_user`: port i occupies `[i*bw_user +: bw_user]`.
- `m_valid` out, 1; `m_ready` in, 1; `m_data` out, `bw_data`; `m_last` out, 1; `m_user` out, `bw_user`: shared output stream.
- `grant_id` out, `$clog2(N_PORTS)`: index of the port that currently owns the output.
- `busy` out, 1: high while a packet is in flight.

## Operation
- FSM with two states, `IDLE` and `BUSY`, held in a registered state variable.
- `IDLE`:
  - All `s_ready` are 0 and `m_valid` is 0.
  - If any `s_valid` bit is high, select the first asserted port scanning upward from `last_grant+1` and wrapping modulo `N_PORTS`.
  - Register that port as `grant_id`, update `last_grant` to it, and move to `BUSY`.
- `BUSY` (combinational pass-through from the granted port `g`):
  - `m_valid = s_valid[g]`; `m_data`, `m_last` and `m_user` come from port g.
  - `s_ready[g] = m_ready`; every other `s_ready` bit is 0.
- Transfer rules:
  - A beat transfers when `m_valid && m_ready`.
  - A transfer with `m_last` = 1 returns the FSM to `IDLE` on the next edge.
  - The grant never changes mid-packet, even if port g deasserts `valid` for any number of cycles.
- Single-beat packets (`last` on the first beat) are legal and occupy `BUSY` for exactly one transfer.
- Fairness: with all ports continuously requesting, grants go 0,1,2,…,N-1,0,… One packet per grant.
- The port just served is scanned last, so another requesting port always wins over it.

## Timing
- Reset values: state `IDLE`, `m_valid` 0, `s_ready` all 0, `busy` 0, `grant_id` 0. `last_grant` resets to `N_PORTS-1`, so port 0 wins the first arbitration.
- `busy` is 1 exactly when the state is `BUSY`.
- Arbitration latency: request seen in `IDLE` at cycle t gives `busy`/`grant_id` at t+1, with the first beat transferable at t+1.
- Inter-packet gap: exactly one `IDLE` cycle after every `last` transfer, so throughput with back-to-back requests is L/(L+1) for L-beat packets.
- Datapath latency is 0 cycles (combinational mux in `BUSY`). The `m_*` signals therefore obey AXI-Stream stability only if the granted source holds its signals stable.
- Simultaneous requests in `IDLE` are resolved by the round-robin pointer alone. A request arriving in the same cycle as a `last` transfer waits for the `IDLE` cycle.
- `Rst` mid-packet: the FSM returns to `IDLE` on the next edge and the partial packet is abandoned. Sources are expected to be reset by the same `Rst`.

## Structure
- Package `axis_arb_pkg` contains:
  - the enum `arb_state_t` {`IDLE`, `BUSY`};
  - the `MAX_PORTS` = 16 constant;
  - the function `rr_next(req, last_grant)`, which returns the next index.
- Sub-module `axis_rr_select`: combinational rotate-priority encoder with inputs `req[N_PORTS]` and `last_grant`, and outputs `gnt_idx` and `gnt_vld`.
- The top level contains only the FSM, the `grant_id`/`last_grant` registers, and the output mux and ready steering.

## Test plan
- Reset then single request: port 2 asserts a 3-beat packet with data 0xA0..0xA2. Expect `busy` rising one cycle later, `grant_id` = 2, three transfers with `m_last` on 0xA2, `IDLE` on the next cycle, and `s_ready[0,1,3]` = 0 throughout.
- All four ports request 2-beat packets continuously. Expect grant order 0,1,2,3,0 and exactly one `IDLE` cycle between packets.
- Backpressure: `m_ready` toggles 1,0,0,1 during a port-1 packet. Expect `s_ready[1]` to mirror `m_ready`, no beat lost or duplicated, and `m_data` matching the source sequence.
- Mid-packet bubble: port 3 drops `s_valid` for 5 cycles between beats while port 0 requests. Expect the grant to stay 3 until its `last`, then port 0 is granted.
- Single-beat packets on ports 0 and 1 (`last` on beat 1). Expect alternating grants 0,1,0 with a 2-cycle period.
- Assert `Rst` while port 2 is mid-packet (beat 2 of 4). Expect the next cycle to show `busy` 0, `m_valid` 0 and `s_ready` all 0, and the following arbitration to grant port 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type, port limit and round-robin helper for the packet arbiter
package axis_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    localparam int MAX_PORTS = 16;
    // Requests above N_PORTS are zero, so scanning modulo MAX_PORTS visits ports in the same order as modulo N_PORTS
    function automatic logic [3:0] rr_next(input logic [MAX_PORTS-1:0] req, input logic [3:0] last_grant);
        logic [3:0] idx;
        rr_next = last_grant;
        for (int k = MAX_PORTS; k >= 1; k--) begin
            idx = last_grant + 4'(k);
            if (req[idx]) rr_next = idx;
        end
    endfunction
endpackage

// File: rtl/axis_rr_select.sv
// axis_rr_select: combinational rotate-priority encoder starting just after last_grant
module axis_rr_select import axis_arb_pkg::*; #(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]         req,
    input  logic [$clog2(N_PORTS)-1:0] last_grant,
    output logic [$clog2(N_PORTS)-1:0] gnt_idx,
    output logic                       gnt_vld
);
    assign gnt_idx = $clog2(N_PORTS)'(rr_next(MAX_PORTS'(req), 4'(last_grant)));
    assign gnt_vld = |req;
endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-level round-robin arbiter sharing one AXI-Stream output among N_PORTS sources
module axis_packet_arbiter import axis_arb_pkg::*; #(
    parameter int N_PORTS = 4,
    parameter int bw_data = 32,
    parameter int bw_user = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [N_PORTS-1:0]           s_valid,
    output logic [N_PORTS-1:0]           s_ready,
    input  logic [N_PORTS*bw_data-1:0]   s_data,
    input  logic [N_PORTS-1:0]           s_last,
    input  logic [N_PORTS*bw_user-1:0]   s_user,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [bw_data-1:0]           m_data,
    output logic                         m_last,
    output logic [bw_user-1:0]           m_user,
    output logic [$clog2(N_PORTS)-1:0]   grant_id,
    output logic                         busy
);
    localparam int IW = $clog2(N_PORTS);
    arb_state_t state, state_n;
    logic [IW-1:0] last_grant, sel_idx;
    logic sel_vld;
    logic [bw_data-1:0] data_a [N_PORTS];
    logic [bw_user-1:0] user_a [N_PORTS];
    for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
        assign data_a[g] = s_data[g*bw_data +: bw_data];
        assign user_a[g] = s_user[g*bw_user +: bw_user];
    end
    axis_rr_select #(.N_PORTS(N_PORTS)) u_sel (
        .req        (s_valid),
        .last_grant (last_grant),
        .gnt_idx    (sel_idx),
        .gnt_vld    (sel_vld)
    );
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(N_PORTS - 1);
        end else begin
            state <= state_n;
            if (state == IDLE && sel_vld) begin
                grant_id   <= sel_idx;
                last_grant <= sel_idx;
            end
        end
    end
    always_comb begin
        m_valid = (state == BUSY) && s_valid[grant_id];
        s_ready = (state == BUSY) ? N_PORTS'(m_ready) << grant_id : '0;
        state_n = (state == IDLE) ? (sel_vld ? BUSY : IDLE)
                                  : ((m_valid && m_ready && m_last) ? IDLE : BUSY);
    end
    assign m_data = data_a[grant_id];
    assign m_user = user_a[grant_id];
    assign m_last = s_last[grant_id];
    assign busy   = state == BUSY;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed stimulus with a scoreboard queue checked by an independent output monitor
module tb_axis_packet_arbiter;
    localparam int N = 4, BD = 32, BU = 8, IW = 2;
    typedef struct { int port; logic [31:0] data; logic last; int gap; } beat_t;
    logic Clk = 1'b0, Rst = 1'b1;
    logic [N-1:0] s_valid, s_ready, s_last, en = '0;
    logic [N*BD-1:0] s_data;
    logic [N*BU-1:0] s_user;
    logic m_valid, m_ready = 1'b1, m_last, busy;
    logic [BD-1:0] m_data;
    logic [BU-1:0] m_user;
    logic [IW-1:0] grant_id;
    logic [32:0] srcq [N][$];
    beat_t expq[$];
    int checks = 0, errors = 0;

    axis_packet_arbiter #(.N_PORTS(N), .bw_data(BD), .bw_user(BU)) dut (
        .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_user(s_user), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_user(m_user), .grant_id(grant_id), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic l);
        srcq[p].push_back({l, d});
    endtask

    task automatic expect_beat(input int p, input logic [31:0] d, input logic l, input int gap);
        expq.push_back('{p, d, l, gap});
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((expq.size() > 0 || srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() > 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(expq.size()), 0);
        step();
        step();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        en = '0;
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) srcq[i].delete();
        expq.delete();
        step();
        step();
        Rst = 1'b0;
    endtask

    // Source models: drive the head of each port queue, pop it when the handshake completes
    initial begin
        logic [32:0] b;
        s_valid = '0; s_last = '0; s_data = '0; s_user = '0;
        forever begin
            @(negedge Clk);
            #1;
            for (int i = 0; i < N; i++) begin
                b = {1'b0, 32'hDEAD_0000 | 32'(i)};
                if (srcq[i].size() > 0) b = srcq[i][0];
                s_valid[i] = en[i] && srcq[i].size() > 0;
                s_last[i] = b[32];
                s_data[i*BD +: BD] = b[31:0];
                s_user[i*BU +: BU] = b[7:0] ^ 8'h5A;
            end
            #3;
            for (int i = 0; i < N; i++)
                if (!Rst && s_valid[i] && s_ready[i]) void'(srcq[i].pop_front());
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks per-cycle ready steering
    initial begin
        beat_t e;
        int cyc = 0, last_x = 0;
        bit prev_last = 0;
        forever begin
            @(negedge Clk);
            #4;
            cyc++;
            if (Rst) prev_last = 0;
            else begin
                if (busy) chk("s_ready_steer", 64'(s_ready), 64'(N'(m_ready) << grant_id));
                else chk("idle_quiet", {m_valid, s_ready}, 0);
                if (prev_last) chk("gap_idle", busy, 0);
                prev_last = 0;
                if (m_valid && m_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", m_data);
                    end else begin
                        e = expq.pop_front();
                        chk("grant_id", grant_id, e.port);
                        chk("m_data", m_data, e.data);
                        chk("m_last", m_last, e.last);
                        chk("m_user", m_user, e.data[7:0] ^ 8'h5A);
                        if (e.gap > 0) chk("beat_gap", cyc - last_x, e.gap);
                    end
                    last_x = cyc;
                    prev_last = m_last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit [3:0] pat = 4'b1001;
        do_reset();
        #4;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_sready", s_ready, 0);

        // single 3-beat request on port 2
        step();
        push(2, 32'hA0, 0); push(2, 32'hA1, 0); push(2, 32'hA2, 1);
        expect_beat(2, 32'hA0, 0, 0); expect_beat(2, 32'hA1, 0, 1); expect_beat(2, 32'hA2, 1, 1);
        en[2] = 1'b1;
        #4;
        chk("t1_busy_pre", busy, 0);
        step();
        #4;
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_id, 2);
        drain(40);

        // all ports continuously requesting 2-beat packets
        do_reset();
        for (int p = 0; p < N; p++) begin
            push(p, 32'h100 * p, 0);
            push(p, 32'h100 * p + 1, 1);
        end
        push(0, 32'h10, 0); push(0, 32'h11, 1);
        expect_beat(0, 32'h000, 0, 0); expect_beat(0, 32'h001, 1, 1);
        expect_beat(1, 32'h100, 0, 2); expect_beat(1, 32'h101, 1, 1);
        expect_beat(2, 32'h200, 0, 2); expect_beat(2, 32'h201, 1, 1);
        expect_beat(3, 32'h300, 0, 2); expect_beat(3, 32'h301, 1, 1);
        expect_beat(0, 32'h010, 0, 2); expect_beat(0, 32'h011, 1, 1);
        en = '1;
        drain(60);

        // backpressure on a port-1 packet
        do_reset();
        for (int b = 0; b < 4; b++) begin
            push(1, 32'hB0 + b, b == 3);
            expect_beat(1, 32'hB0 + b, b == 3, 0);
        end
        en[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_ready = pat[i % 4];
            step();
        end
        m_ready = 1'b1;
        drain(40);

        // port 3 bubbles mid-packet while port 0 waits
        do_reset();
        push(3, 32'hC0, 0); push(3, 32'hC1, 0); push(3, 32'hC2, 1);
        expect_beat(3, 32'hC0, 0, 0); expect_beat(3, 32'hC1, 0, 0); expect_beat(3, 32'hC2, 1, 1);
        expect_beat(0, 32'hD0, 1, 2);
        en[3] = 1'b1;
        step();
        step();
        en[3] = 1'b0;
        push(0, 32'hD0, 1);
        en[0] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #4;
            chk("t4_hold_grant", grant_id, 3);
            chk("t4_hold_busy", busy, 1);
            step();
        end
        en[3] = 1'b1;
        drain(40);

        // single-beat packets on ports 0 and 1
        do_reset();
        push(0, 32'hE0, 1); push(0, 32'hE2, 1); push(1, 32'hE1, 1);
        expect_beat(0, 32'hE0, 1, 0); expect_beat(1, 32'hE1, 1, 2); expect_beat(0, 32'hE2, 1, 2);
        en = 4'b0011;
        drain(40);

        // reset while port 2 is mid-packet
        do_reset();
        for (int b = 0; b < 4; b++) push(2, 32'hF0 + b, b == 3);
        expect_beat(2, 32'hF0, 0, 0); expect_beat(2, 32'hF1, 0, 1);
        expect_beat(0, 32'h60, 1, 0); expect_beat(3, 32'h70, 1, 2);
        en[2] = 1'b1;
        step();
        step();
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        srcq[2].delete();
        en[2] = 1'b0;
        push(0, 32'h60, 1);
        push(3, 32'h70, 1);
        en[0] = 1'b1;
        en[3] = 1'b1;
        #4;
        chk("t6_busy", busy, 0);
        chk("t6_mvalid", m_valid, 0);
        chk("t6_sready", s_ready, 0);
        step();
        #4;
        chk("t6_grant", grant_id, 0);
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
